fifo_packet_reader: RTL

- Downstream consumer of the 8kx9 block-RAM FIFO (standard read mode, not first-word-fall-through; data valid one cycle after the read enable).
- Each 9-bit FIFO word is a byte plus bit 8, a start-of-packet marker. A packet is one header word (bit8=1, command byte), one length word (bit8=0, N), then N payload words (bit8=0).
- The block pops the FIFO and parses packets into a command/length strobe plus a ready/valid payload byte stream. It reports framing errors and resynchronises on them.

---
 rtl/fifo_pkt_pkg.sv | 11 +
 rtl/fifo_skid_buf2.sv | 58 +++++
 rtl/fifo_packet_reader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fifo_pkt_pkg.sv
// Shared constants for the packet reader: FIFO word layout and FSM state codes.
package fifo_pkt_pkg;
    localparam int WORD_W  = 9;
    localparam int SOP_BIT = 8;

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;

    typedef logic [WORD_W-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry holding buffer behind a standard-mode FIFO; issues pops so that
// buffered plus in-flight words never exceed the two slots.
module fifo_skid_buf2
    import fifo_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  fifo_word_t fifo_dout,
    input  logic       fifo_valid,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    input  logic       pop,
    output logic       head_valid,
    output fifo_word_t head
);
    fifo_word_t mem [2];
    logic [1:0] count;
    logic       inflight;
    logic       push;
    logic       pop_ok;

    assign fifo_rd_en = !srst && !fifo_empty && ((count + {1'b0, inflight}) < 2'd2);
    // Read data that was never requested (e.g. straddling a reset) is dropped.
    assign push       = fifo_valid && inflight;
    assign head_valid = (count != 2'd0);
    assign pop_ok     = pop && head_valid;
    assign head       = mem[0];

    always_ff @(posedge clk) begin
        if (srst) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            mem[0]   <= '0;
            mem[1]   <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({push, pop_ok})
                2'b10: begin
                    mem[count[0]] <= fifo_dout;
                    count         <= count + 2'd1;
                end
                2'b01: begin
                    mem[0] <= mem[1];
                    count  <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem[0] <= fifo_dout;
                    end else begin
                        mem[0] <= mem[1];
                        mem[1] <= fifo_dout;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/fifo_packet_reader.sv
// Parses SOP-framed packets from the holding buffer into a header strobe and a
// ready/valid payload stream, counting and resynchronising on framing errors.
module fifo_packet_reader
    import fifo_pkt_pkg::*;
#(
    parameter int LenWidth      = 8,
    parameter int ErrCountWidth = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic [WORD_W-1:0]        fifo_dout,
    input  logic                     fifo_valid,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    output logic                     hdr_valid,
    output logic [7:0]               hdr_cmd,
    output logic [LenWidth-1:0]      hdr_len,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     pkt_done,
    output logic [ErrCountWidth-1:0] err_count
);
    logic                     head_valid;
    fifo_word_t               head;
    logic                     pop;
    logic [1:0]               state, next_state;
    logic [LenWidth-1:0]      remaining, next_rem;
    logic [7:0]               cmd_q, next_cmd;
    logic [7:0]               hdr_cmd_q;
    logic [LenWidth-1:0]      hdr_len_q;
    logic [ErrCountWidth-1:0] err_q;
    logic                     err_inc;
    logic                     sop;
    logic [LenWidth-1:0]      len_word;

    fifo_skid_buf2 u_buf (
        .clk       (clk),
        .srst      (srst),
        .fifo_dout (fifo_dout),
        .fifo_valid(fifo_valid),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .pop       (pop),
        .head_valid(head_valid),
        .head      (head)
    );

    assign sop      = head[SOP_BIT];
    assign len_word = LenWidth'(head[7:0]);

    always_comb begin
        pop        = 1'b0;
        hdr_valid  = 1'b0;
        pkt_done   = 1'b0;
        err_inc    = 1'b0;
        out_valid  = 1'b0;
        next_state = state;
        next_rem   = remaining;
        next_cmd   = cmd_q;
        if (head_valid && !srst) begin
            case (state)
                ST_HUNT: begin
                    pop = 1'b1;
                    if (sop) begin
                        next_cmd   = head[7:0];
                        next_state = ST_LEN;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                ST_LEN: begin
                    pop = 1'b1;
                    if (sop) begin
                        err_inc  = 1'b1;
                        next_cmd = head[7:0];
                    end else begin
                        hdr_valid = 1'b1;
                        if (len_word == '0) begin
                            pkt_done   = 1'b1;
                            next_state = ST_HUNT;
                        end else begin
                            next_rem   = len_word;
                            next_state = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // A new SOP here means the packet was truncated: resync on it.
                    if (sop) begin
                        pop        = 1'b1;
                        err_inc    = 1'b1;
                        next_cmd   = head[7:0];
                        next_state = ST_LEN;
                    end else begin
                        out_valid = 1'b1;
                        if (out_ready) begin
                            pop      = 1'b1;
                            next_rem = remaining - LenWidth'(1);
                            if (remaining == LenWidth'(1)) begin
                                pkt_done   = 1'b1;
                                next_state = ST_HUNT;
                            end
                        end
                    end
                end
                default: next_state = ST_HUNT;
            endcase
        end
    end

    assign out_data  = out_valid ? head[7:0] : 8'h00;
    assign out_last  = out_valid && (remaining == LenWidth'(1));
    assign hdr_cmd   = hdr_valid ? cmd_q : hdr_cmd_q;
    assign hdr_len   = hdr_valid ? len_word : hdr_len_q;
    assign err_count = err_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= ST_HUNT;
            remaining <= '0;
            cmd_q     <= 8'h00;
            hdr_cmd_q <= 8'h00;
            hdr_len_q <= '0;
            err_q     <= '0;
        end else begin
            state     <= next_state;
            remaining <= next_rem;
            cmd_q     <= next_cmd;
            if (hdr_valid) begin
                hdr_cmd_q <= cmd_q;
                hdr_len_q <= len_word;
            end
            if (err_inc && (err_q != '1))
                err_q <= err_q + ErrCountWidth'(1);
        end
    end
endmodule
